// File: rtl/demux_dispatch_ctrl.sv
// One-item dispatch controller for a 1-to-8 demux: burst round-robin sink selection + stall watchdog.
// Optional per-sink enable mask when DEMUX_DISPATCH_MASK_EN is defined.
module demux_dispatch_ctrl #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned BURST   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [2:0]       sel,
  output logic [WIDTH-1:0] out_data,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ready,
`ifdef DEMUX_DISPATCH_MASK_EN
  input  logic [7:0]       sink_mask,
`endif
  output logic             busy,
  output logic             drop_err,
  input  logic             clr_err
);

  localparam logic [7:0] BurstLast   = 8'(BURST - 1);
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [0:0] {StEmpty, StHold} state_e;

  state_e           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [7:0]       burst_q, burst_d;
  logic [7:0]       stall_q, stall_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;

  logic       fire, load, drop, can_load;
  logic [2:0] tgt, nxt;
  logic [7:0] burst_base;

`ifdef DEMUX_DISPATCH_MASK_EN
  // First enabled index strictly after start, wrapping; start itself is the last candidate.
  function automatic logic [2:0] next_en(input logic [2:0] start, input logic [7:0] mask);
    logic [2:0] idx;
    next_en = start;
    for (int i = 7; i >= 1; i--) begin
      idx = start + 3'(i);
      if (mask[idx]) next_en = idx;
    end
  endfunction
`endif

  always_comb begin
`ifdef DEMUX_DISPATCH_MASK_EN
    can_load   = |sink_mask;
    tgt        = sink_mask[ptr_q] ? ptr_q : next_en(ptr_q, sink_mask);
    // A disabled pointer is skipped, so the newly chosen sink starts a fresh burst.
    burst_base = sink_mask[ptr_q] ? burst_q : 8'd0;
    nxt        = next_en(tgt, sink_mask);
`else
    can_load   = 1'b1;
    tgt        = ptr_q;
    burst_base = burst_q;
    nxt        = tgt + 3'd1;
`endif
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    burst_d   = burst_q;
    stall_d   = stall_q;
    data_d    = data_q;
    drop      = 1'b0;

    fire      = (state_q == StHold) & out_ready[sel_q];
    in_ready  = can_load & ((state_q == StEmpty) | fire);
    load      = in_valid & in_ready;
    out_valid = (state_q == StHold) ? (8'd1 << sel_q) : 8'd0;
    busy      = (state_q == StHold);
    out_data  = data_q;
    sel       = sel_q;
    drop_err  = err_q;

    unique case (state_q)
      StEmpty: ;
      StHold: begin
        if (fire) begin
          state_d = StEmpty;
        end else if (stall_q == TimeoutLast) begin
          state_d = StEmpty;
          drop    = 1'b1;
        end else begin
          stall_d = stall_q + 8'd1;
        end
      end
      default: state_d = StEmpty;
    endcase

    if (load) begin
      state_d = StHold;
      stall_d = 8'd0;
      data_d  = in_data;
      sel_d   = tgt;
      if (burst_base == BurstLast) begin
        burst_d = 8'd0;
        ptr_d   = nxt;
      end else begin
        burst_d = burst_base + 8'd1;
        ptr_d   = tgt;
      end
    end

    // A new drop outranks a simultaneous clear.
    if (drop)         err_d = 1'b1;
    else if (clr_err) err_d = 1'b0;
    else              err_d = err_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StEmpty;
      sel_q   <= 3'd0;
      ptr_q   <= 3'd0;
      burst_q <= 8'd0;
      stall_q <= 8'd0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      stall_q <= stall_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Directed self-checking bench for demux_dispatch_ctrl (WIDTH=8, BURST=4, TIMEOUT=16).
module tb_demux_dispatch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [2:0] sel;
  logic [7:0] out_data;
  logic [7:0] out_valid;
  logic [7:0] out_ready;
  logic       busy;
  logic       drop_err;
  logic       clr_err;
`ifdef DEMUX_DISPATCH_MASK_EN
  logic [7:0] sink_mask = 8'hFF;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  demux_dispatch_ctrl #(.WIDTH(8), .BURST(4), .TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef DEMUX_DISPATCH_MASK_EN
    .sink_mask (sink_mask),
`endif
    .busy      (busy),
    .drop_err  (drop_err),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic [2:0] exp_sel;
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 8'h00; clr_err = 1'b0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'h00);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_drop_err", 32'(drop_err), 32'h0);
    #10 reset = 1'b0;
    tick();

    // Stream 33 items with every sink ready: 4 per sink, pointer wraps 7 -> 0.
    out_ready = 8'hFF;
    for (int n = 1; n <= 33; n++) begin
      in_valid = 1'b1;
      in_data  = 8'(n);
      settle();
      chk("stream_in_ready", 32'(in_ready), 32'h1);
      tick();
      exp_sel = 3'(((n - 1) / 4) % 8);
      chk("stream_out_data", 32'(out_data), 32'(n));
      chk("stream_sel", 32'(sel), 32'(exp_sel));
      chk("stream_out_valid", 32'(out_valid), 32'(8'd1 << exp_sel));
      chk("stream_busy", 32'(busy), 32'h1);
    end
    in_valid = 1'b0;
    settle();
    tick();
    chk("stream_idle_busy", 32'(busy), 32'h0);
    chk("stream_idle_valid", 32'(out_valid), 32'h00);

    // Backpressure on sink 0; other sinks' ready bits must be ignored.
    out_ready = 8'hFE;
    in_valid = 1'b1; in_data = 8'h55;
    settle();
    tick();
    in_data = 8'h66;
    settle();
    for (int i = 0; i < 3; i++) begin
      chk("hold_out_data", 32'(out_data), 32'h55);
      chk("hold_sel", 32'(sel), 32'h0);
      chk("hold_in_ready", 32'(in_ready), 32'h0);
      chk("hold_busy", 32'(busy), 32'h1);
      tick();
    end
    out_ready = 8'hFF;
    settle();
    chk("hold_fire_in_ready", 32'(in_ready), 32'h1);
    tick();
    chk("hold_next_data", 32'(out_data), 32'h66);
    chk("hold_next_sel", 32'(sel), 32'h0);
    in_valid = 1'b0;
    settle();
    tick();
    chk("hold_done_busy", 32'(busy), 32'h0);
    chk("hold_drop_err", 32'(drop_err), 32'h0);

    // Fourth item on sink 0 rotates pointer to 1.
    in_valid = 1'b1; in_data = 8'h70;
    settle();
    tick();
    chk("rot_sel", 32'(sel), 32'h0);
    in_valid = 1'b0;
    settle();
    tick();

    // Watchdog: item on sink 1 dropped 16 cycles after load.
    out_ready = 8'h00;
    in_valid = 1'b1; in_data = 8'h77;
    settle();
    tick();
    chk("to_sel", 32'(sel), 32'h1);
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("to_last_busy", 32'(busy), 32'h1);
    chk("to_last_err", 32'(drop_err), 32'h0);
    tick();
    chk("to_drop_busy", 32'(busy), 32'h0);
    chk("to_drop_valid", 32'(out_valid), 32'h00);
    chk("to_drop_err", 32'(drop_err), 32'h1);
    out_ready = 8'hFF;
    in_valid = 1'b1; in_data = 8'h88;
    settle();
    chk("to_next_in_ready", 32'(in_ready), 32'h1);
    tick();
    chk("to_next_sel", 32'(sel), 32'h1);
    chk("to_next_data", 32'(out_data), 32'h88);
    chk("to_err_sticky", 32'(drop_err), 32'h1);
    in_valid = 1'b0;
    settle();
    tick();
    clr_err = 1'b1;
    settle();
    tick();
    chk("clr_err", 32'(drop_err), 32'h0);
    clr_err = 1'b0;

    // Fire on the final timeout cycle beats the drop.
    out_ready = 8'h00;
    in_valid = 1'b1; in_data = 8'h99;
    settle();
    tick();
    chk("late_sel", 32'(sel), 32'h1);
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    out_ready = 8'hFF;
    settle();
    chk("late_in_ready", 32'(in_ready), 32'h1);
    tick();
    chk("late_busy", 32'(busy), 32'h0);
    chk("late_err", 32'(drop_err), 32'h0);

    // Drop coinciding with clr_err: set wins.
    out_ready = 8'h00;
    in_valid = 1'b1; in_data = 8'hAA;
    settle();
    tick();
    chk("setwin_sel", 32'(sel), 32'h1);
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    clr_err = 1'b1;
    settle();
    tick();
    chk("setwin_err", 32'(drop_err), 32'h1);
    chk("setwin_busy", 32'(busy), 32'h0);
    clr_err = 1'b0;

    // Fill sink 2, park next item on sink 3, then reset mid-hold.
    out_ready = 8'hFF;
    for (int n = 0; n < 4; n++) begin
      in_valid = 1'b1; in_data = 8'(8'hB0 + n);
      settle();
      tick();
      chk("pre_rst_sel", 32'(sel), 32'h2);
    end
    in_data = 8'hC0;
    settle();
    tick();
    in_valid = 1'b0; out_ready = 8'h00;
    settle();
    chk("pre_rst_sel3", 32'(sel), 32'h3);
    chk("pre_rst_valid", 32'(out_valid), 32'h08);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'h00);
    chk("async_rst_sel", 32'(sel), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_data", 32'(out_data), 32'h00);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("post_rst_valid", 32'(out_valid), 32'h00);
    out_ready = 8'hFF;
    in_valid = 1'b1; in_data = 8'hD0;
    settle();
    tick();
    chk("post_rst_sel", 32'(sel), 32'h0);
    chk("post_rst_data", 32'(out_data), 32'hD0);
    in_valid = 1'b0;
    settle();
    tick();

`ifdef DEMUX_DISPATCH_MASK_EN
    // Mask 1000_0101: bursts of 4 on sinks 0, 2, 7, then back to 0.
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    tick();
    sink_mask = 8'b1000_0101;
    for (int n = 1; n <= 13; n++) begin
      in_valid = 1'b1; in_data = 8'(n);
      settle();
      tick();
      case ((n - 1) / 4)
        0:       exp_sel = 3'd0;
        1:       exp_sel = 3'd2;
        2:       exp_sel = 3'd7;
        default: exp_sel = 3'd0;
      endcase
      chk("mask_sel", 32'(sel), 32'(exp_sel));
    end
    in_valid = 1'b0;
    settle();
    tick();
    sink_mask = 8'h00;
    in_valid = 1'b1; in_data = 8'hEE;
    settle();
    chk("mask_zero_in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("mask_zero_busy", 32'(busy), 32'h0);
    in_valid = 1'b0;
    sink_mask = 8'hFF;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
